// File: rtl/fp_alu_pkg.sv
// Shared definitions for the fp_alu command front-end: opcodes, canned NaN, FSM states, FIFO entry layout.
// Entry layout in the command FIFO is {tag, op, b, a}; the body struct covers {op, b, a}.
package fp_alu_pkg;

    localparam logic [2:0]  OP_ADD = 3'b000;
    localparam logic [2:0]  OP_SUB = 3'b001;
    localparam logic [2:0]  OP_MUL = 3'b010;
    localparam logic [2:0]  OP_DIV = 3'b011;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_START   = 2'd1,
        S_WAIT    = 2'd2,
        S_CAPTURE = 2'd3
    } disp_state_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] b;
        logic [31:0] a;
    } cmd_body_t;

    localparam int CMD_BODY_W = $bits(cmd_body_t);

    // The core only implements opcodes with bit 2 clear.
    function automatic logic op_supported(input logic [2:0] op);
        return !op[2];
    endfunction

endpackage

// File: rtl/fp_cmd_fifo.sv
// Synchronous FIFO, registered storage; head entry is visible the cycle after its push (no bypass).
// Push is ignored when full and pop is ignored when empty, so callers may gate with full/empty or not.
module fp_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        push_dat_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        head_dat_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fp_alu_dispatcher.sv
// Queues tagged FP commands and sequences the fp_alu start/ready handshake; 9-cycle accept-to-response with an idle core.
// Pops only when the core is ready and the response register can take a result; rsp_ready low stalls capture.
module fp_alu_dispatcher
    import fp_alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [31:0]              cmd_a,
    input  logic [31:0]              cmd_b,
    input  logic [2:0]               cmd_op,
    input  logic [TAG_W-1:0]         cmd_tag,
    output logic                     alu_start,
    output logic [31:0]              alu_operand_a,
    output logic [31:0]              alu_operand_b,
    output logic [2:0]               alu_opcode,
    input  logic [31:0]              alu_result,
    input  logic                     alu_invalid,
    input  logic                     alu_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_result,
    output logic                     rsp_invalid,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int ENTRY_W = TAG_W + CMD_BODY_W;

    cmd_body_t          push_body;
    cmd_body_t          head_body;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic [TAG_W-1:0]   head_tag;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               rsp_free;

    disp_state_t        state_q;
    logic               start_q;
    logic [31:0]        opa_q;
    logic [31:0]        opb_q;
    logic [2:0]         op_q;
    logic [TAG_W-1:0]   tag_q;
    logic               rsp_valid_q;
    logic [31:0]        rsp_result_q;
    logic               rsp_invalid_q;
    logic [TAG_W-1:0]   rsp_tag_q;

    always_comb begin
        push_body    = '0;
        push_body.op = cmd_op;
        push_body.b  = cmd_b;
        push_body.a  = cmd_a;
    end

    assign push_entry = {cmd_tag, push_body};
    assign head_body  = cmd_body_t'(head_entry[CMD_BODY_W-1:0]);
    assign head_tag   = head_entry[ENTRY_W-1:CMD_BODY_W];

    // The response register is free if empty or draining this cycle.
    assign rsp_free = !rsp_valid_q || rsp_ready;
    assign pop      = (state_q == S_IDLE) && !fifo_empty && alu_ready && rsp_free;

    fp_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (cmd_valid && cmd_ready),
        .push_dat_i (push_entry),
        .pop_i      (pop),
        .head_dat_o (head_entry),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            start_q       <= 1'b0;
            opa_q         <= '0;
            opb_q         <= '0;
            op_q          <= '0;
            tag_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_invalid_q <= 1'b0;
            rsp_tag_q     <= '0;
        end else begin
            if (rsp_valid_q && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        if (!op_supported(head_body.op)) begin
                            rsp_valid_q   <= 1'b1;
                            rsp_result_q  <= QNAN;
                            rsp_invalid_q <= 1'b1;
                            rsp_tag_q     <= head_tag;
                        end else begin
                            opa_q   <= head_body.a;
                            opb_q   <= head_body.b;
                            op_q    <= head_body.op;
                            tag_q   <= head_tag;
                            start_q <= 1'b1;
                            state_q <= S_START;
                        end
                    end
                end
                S_START: begin
                    start_q <= 1'b0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (alu_ready) begin
                        state_q <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    // Operands stay on the bus until here; the core holds its result while we stall.
                    if (rsp_free) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_result_q  <= alu_result;
                        rsp_invalid_q <= alu_invalid;
                        rsp_tag_q     <= tag_q;
                        state_q       <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = !fifo_full;
    assign alu_start     = start_q;
    assign alu_operand_a = opa_q;
    assign alu_operand_b = opb_q;
    assign alu_opcode    = op_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_result    = rsp_result_q;
    assign rsp_invalid   = rsp_invalid_q;
    assign rsp_tag       = rsp_tag_q;
    assign busy          = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_fp_alu_dispatcher.sv
// Directed bench for fp_alu_dispatcher with a behavioural fp_alu core (ready drops on start, result 6 edges later).
module tb_fp_alu_dispatcher;
    import fp_alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [31:0]       cmd_a;
    logic [31:0]       cmd_b;
    logic [2:0]        cmd_op;
    logic [TAG_W-1:0]  cmd_tag;
    logic              alu_start;
    logic [31:0]       alu_operand_a;
    logic [31:0]       alu_operand_b;
    logic [2:0]        alu_opcode;
    logic [31:0]       alu_result;
    logic              alu_invalid;
    logic              alu_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_result;
    logic              rsp_invalid;
    logic [TAG_W-1:0]  rsp_tag;
    logic              busy;
    logic [$clog2(DEPTH):0] fifo_count;

    always #5 clk = ~clk;

    fp_alu_dispatcher #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .alu_start(alu_start), .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
        .alu_opcode(alu_opcode), .alu_result(alu_result), .alu_invalid(alu_invalid),
        .alu_ready(alu_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_invalid(rsp_invalid), .rsp_tag(rsp_tag),
        .busy(busy), .fifo_count(fifo_count)
    );

    // Core stand-in: knows the exact results of the vectors used here; samples operands at completion.
    function automatic logic [32:0] core_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == OP_ADD && a == 32'h3F800000 && b == 32'h40000000) return {1'b0, 32'h40400000};
        if (op == OP_ADD && a == 32'h40000000 && b == 32'h40000000) return {1'b0, 32'h40800000};
        if (op == OP_MUL && a == 32'h40000000 && b == 32'h40400000) return {1'b0, 32'h40C00000};
        if (op == OP_SUB && a == 32'h40400000 && b == 32'h3F800000) return {1'b0, 32'h40000000};
        if (op == OP_DIV && b == 32'h00000000) return {1'b1, 32'h00000000};
        return {1'b0, a ^ b ^ {29'd0, op}};
    endfunction

    int core_cnt;
    always @(posedge clk) begin
        if (reset) begin
            alu_ready   <= 1'b1;
            alu_result  <= '0;
            alu_invalid <= 1'b0;
            core_cnt    <= 0;
        end else if (alu_ready && alu_start) begin
            alu_ready <= 1'b0;
            core_cnt  <= 5;
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                alu_ready <= 1'b1;
                {alu_invalid, alu_result} <= core_fn(alu_opcode, alu_operand_a, alu_operand_b);
            end
        end
    end

    int   start_cnt = 0;
    int   start_double = 0;
    logic start_prev = 1'b0;
    always @(negedge clk) begin
        if (alu_start) start_cnt++;
        if (alu_start && start_prev) start_double++;
        start_prev = alu_start;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]       op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
        logic [31:0]      res;
        logic             inv;
        int               lat;
        int               starts;
    } vec_t;

    vec_t vecs[6];
    vec_t bp[6];

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_timeout", 64'(n < 50), 64'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || rsp_valid) && n < 60) begin
            @(posedge clk);
            #1 n++;
        end
        chk("idle_timeout", 64'(n < 60), 64'd1);
    endtask

    task automatic run_one(input string nm, input vec_t v);
        int lat;
        int s0;
        s0 = start_cnt;
        send(v.op, v.a, v.b, v.tag);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        chk({nm, "_lat"}, 64'(lat), 64'(v.lat));
        chk({nm, "_res"}, 64'(rsp_result), 64'(v.res));
        chk({nm, "_inv"}, 64'(rsp_invalid), 64'(v.inv));
        chk({nm, "_tag"}, 64'(rsp_tag), 64'(v.tag));
        wait_idle();
        chk({nm, "_starts"}, 64'(start_cnt - s0), 64'(v.starts));
    endtask

    task automatic check_reset_values(input string nm);
        chk({nm, "_rsp_valid"},   64'(rsp_valid), 64'd0);
        chk({nm, "_rsp_result"},  64'(rsp_result), 64'd0);
        chk({nm, "_rsp_invalid"}, 64'(rsp_invalid), 64'd0);
        chk({nm, "_rsp_tag"},     64'(rsp_tag), 64'd0);
        chk({nm, "_alu_start"},   64'(alu_start), 64'd0);
        chk({nm, "_opa"},         64'(alu_operand_a), 64'd0);
        chk({nm, "_opb"},         64'(alu_operand_b), 64'd0);
        chk({nm, "_opcode"},      64'(alu_opcode), 64'd0);
        chk({nm, "_busy"},        64'(busy), 64'd0);
        chk({nm, "_fifo_count"},  64'(fifo_count), 64'd0);
        chk({nm, "_cmd_ready"},   64'(cmd_ready), 64'd1);
    endtask

    initial begin
        logic [31:0]      got_r[$];
        logic [TAG_W-1:0] got_tag[$];
        logic             got_inv[$];
        int               got_t[$];
        int               n;
        vec_t             v;

        vecs[0] = '{OP_ADD, 32'h3F800000, 32'h40000000, 4'd3,  32'h40400000, 1'b0, 9, 1};
        vecs[1] = '{OP_DIV, 32'h3F800000, 32'h00000000, 4'd4,  32'h00000000, 1'b1, 9, 1};
        vecs[2] = '{3'b101, 32'h3F800000, 32'h40000000, 4'd7,  32'h7FC00000, 1'b1, 1, 0};
        vecs[3] = '{3'b111, 32'h12345678, 32'h9ABCDEF0, 4'd15, 32'h7FC00000, 1'b1, 1, 0};
        vecs[4] = '{OP_MUL, 32'h40000000, 32'h40400000, 4'd5,  32'h40C00000, 1'b0, 9, 1};
        vecs[5] = '{OP_SUB, 32'h40400000, 32'h3F800000, 4'd0,  32'h40000000, 1'b0, 9, 1};

        bp[0] = '{OP_ADD, 32'h3F800000, 32'h40000000, 4'd8,  32'h40400000, 1'b0, 0, 0};
        bp[1] = '{OP_MUL, 32'h40000000, 32'h40400000, 4'd9,  32'h40C00000, 1'b0, 0, 0};
        bp[2] = '{OP_SUB, 32'h40400000, 32'h3F800000, 4'd10, 32'h40000000, 1'b0, 0, 0};
        bp[3] = '{OP_DIV, 32'h3F800000, 32'h00000000, 4'd11, 32'h00000000, 1'b1, 0, 0};
        bp[4] = '{3'b110, 32'h3F800000, 32'h3F800000, 4'd12, 32'h7FC00000, 1'b1, 0, 0};
        bp[5] = '{OP_ADD, 32'h40000000, 32'h40000000, 4'd13, 32'h40800000, 1'b0, 0, 0};

        reset = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_reset_values("rst0");
        @(negedge clk) reset = 1'b0;

        // Single commands, one at a time.
        for (int i = 0; i < 6; i++) begin
            run_one($sformatf("v%0d", i), vecs[i]);
        end

        // Back-to-back MUL then SUB: in order, 9 cycles apart.
        send(bp[1].op, bp[1].a, bp[1].b, 4'd1);
        cmd_valid = 1'b1; cmd_op = OP_SUB; cmd_a = 32'h40400000; cmd_b = 32'h3F800000; cmd_tag = 4'd2;
        for (int t = 0; t < 40; t++) begin
            if (t == 1) cmd_valid = 1'b0;
            if (rsp_valid) begin
                got_t.push_back(t); got_r.push_back(rsp_result); got_tag.push_back(rsp_tag);
            end
            @(posedge clk);
            #1;
        end
        chk("b2b_count", 64'(got_t.size()), 64'd2);
        if (got_t.size() == 2) begin
            chk("b2b_t0",   64'(got_t[0]), 64'd9);
            chk("b2b_gap",  64'(got_t[1] - got_t[0]), 64'd9);
            chk("b2b_r0",   64'(got_r[0]), 64'h40C00000);
            chk("b2b_r1",   64'(got_r[1]), 64'h40000000);
            chk("b2b_tag0", 64'(got_tag[0]), 64'd1);
            chk("b2b_tag1", 64'(got_tag[1]), 64'd2);
        end
        wait_idle();

        // Backpressure: 1 in flight plus 4 queued fills the FIFO, the 6th waits.
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            v = bp[i];
            send(v.op, v.a, v.b, v.tag);
        end
        @(negedge clk);
        chk("bp_cmd_ready_full", 64'(cmd_ready), 64'd0);
        chk("bp_count_full", 64'(fifo_count), 64'd4);
        repeat (12) @(negedge clk);
        chk("bp_held_valid", 64'(rsp_valid), 64'd1);
        chk("bp_held_tag",   64'(rsp_tag), 64'd8);
        chk("bp_count_hold", 64'(fifo_count), 64'd4);
        chk("bp_ready_hold", 64'(cmd_ready), 64'd0);
        got_r.delete(); got_tag.delete(); got_inv.delete();
        cmd_valid = 1'b1; cmd_op = bp[5].op; cmd_a = bp[5].a; cmd_b = bp[5].b; cmd_tag = bp[5].tag;
        rsp_ready = 1'b1;
        fork
            begin
                int m;
                m = 0;
                while (!cmd_ready && m < 100) begin
                    @(negedge clk);
                    m++;
                end
                chk("bp_push6_timeout", 64'(m < 100), 64'd1);
                @(posedge clk);
                #1 cmd_valid = 1'b0;
            end
            begin
                int m;
                m = 0;
                while (got_r.size() < 6 && m < 200) begin
                    if (rsp_valid && rsp_ready) begin
                        got_r.push_back(rsp_result); got_tag.push_back(rsp_tag);
                        got_inv.push_back(rsp_invalid);
                    end
                    @(negedge clk);
                    m++;
                end
            end
        join
        chk("bp_count", 64'(got_r.size()), 64'd6);
        for (int i = 0; i < got_r.size() && i < 6; i++) begin
            chk($sformatf("bp%0d_tag", i), 64'(got_tag[i]), 64'(bp[i].tag));
            chk($sformatf("bp%0d_res", i), 64'(got_r[i]), 64'(bp[i].res));
            chk($sformatf("bp%0d_inv", i), 64'(got_inv[i]), 64'(bp[i].inv));
        end
        wait_idle();

        // Reset mid-operation with a second command queued.
        send(OP_ADD, 32'h3F800000, 32'h40000000, 4'd1);
        send(OP_ADD, 32'h40000000, 32'h40000000, 4'd2);
        n = 0;
        while (!alu_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_start_seen", 64'(alu_start), 64'd1);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 check_reset_values("rst1");
        @(negedge clk) reset = 1'b0;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        chk("rst_no_rsp", 64'(n), 64'd0);
        run_one("post_rst", vecs[0]);

        chk("start_one_cycle", 64'(start_double), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_alu_dispatcher.md
Name: fp_alu_dispatcher

Overview:
- Command front-end placed directly upstream of the fp_alu core. It buffers tagged FP commands in a small FIFO and drives the core's start/ready handshake, holding operands and opcode stable for the whole operation.
- It captures the core's result and invalid flag into a registered, tagged response port with valid/ready backpressure.
- Unsupported opcodes are filtered here and never reach the core.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, ≥2)
TAG_W, 4, width of the opaque command tag returned with the response

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO not full
cmd_a  in  32  operand A (IEEE754 single)
cmd_b  in  32  operand B
cmd_op  in  3  000 add, 001 sub, 010 mul, 011 div
cmd_tag  in  TAG_W  command tag
alu_start  out  1  to core start
alu_operand_a  out  32  to core operand_a
alu_operand_b  out  32  to core operand_b
alu_opcode  out  3  to core opcode
alu_result  in  32  from core result
alu_invalid  in  1  from core invalid
alu_ready  in  1  from core ready
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts
rsp_result  out  32  result
rsp_invalid  out  1  invalid flag
rsp_tag  out  TAG_W  tag of the originating command
busy  out  1  FSM not in S_IDLE, or FIFO non-empty
fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset clears all registers, empties the FIFO and returns the FSM to S_IDLE. The core uses the same reset net.
- Reset values: rsp_valid=0, rsp_result=0, rsp_invalid=0, rsp_tag=0, alu_start=0, alu_operand_a/b=0, alu_opcode=0, busy=0, fifo_count=0, cmd_ready=1.
- Reset mid-operation abandons the in-flight command and all queued commands. No response is produced for them.
- Command push: cmd_valid && cmd_ready. cmd_ready = !full.
  - No push-through-when-full.
  - No bypass: a pushed entry is poppable the cycle after the push.
  - Simultaneous push and pop updates the count by 0.
- FSM states and transitions:
  - S_IDLE: pop when FIFO non-empty, alu_ready=1, and (rsp_valid=0 or rsp_ready=1).
    - cmd_op[2]=1: load the response register with 0x7FC00000, invalid=1 and the entry's tag; stay in S_IDLE.
    - Otherwise: register the operands, opcode and tag; set alu_start=1; go to S_START.
  - S_START: alu_start=1 for exactly this one cycle. Deassert and go to S_WAIT.
  - S_WAIT: wait for alu_ready==1, then go to S_CAPTURE. The core drops ready on the edge that consumes start, so the first S_WAIT cycle already sees 0.
  - S_CAPTURE: when rsp_valid=0 or rsp_ready=1, load rsp_result/rsp_invalid from alu_result/alu_invalid plus the held tag, set rsp_valid=1, go to S_IDLE. Otherwise stall; the core holds its result.
- alu_operand_a/b, alu_opcode and the held tag stay constant from pop until capture. The core samples opcode several cycles after start.
- Response port:
  - rsp_valid clears on rsp_valid && rsp_ready unless reloaded in the same cycle.
  - A new load while the old response drains in the same cycle is legal.
- Latency, empty FIFO, idle core, rsp_ready=1:
  - Accept edge E0, pop and start high after E1, core busy edges E2–E8.
  - rsp_valid rises after E9: 9 cycles.
  - Throughput is one op per 9 cycles.
  - Unsupported opcode: rsp_valid after E1.
- Responses return in command order.

Decomposition:
- fp_alu_pkg:
  - opcode localparams OP_ADD/SUB/MUL/DIV
  - QNAN = 32'h7FC00000
  - dispatcher state encodings
  - FIFO entry layout: {tag, op, b, a}
- One sub-module, fp_cmd_fifo: synchronous FIFO parameterised by DEPTH and entry width, exposing full, empty and count.

Test Plan:
- ADD, a=0x3F800000, b=0x40000000, tag=3 -> rsp_result=0x40400000, invalid=0, tag=3, rsp_valid 9 cycles after accept.
- MUL 0x40000000 × 0x40400000 followed back-to-back by SUB 0x40400000 − 0x3F800000 -> responses 0x40C00000 then 0x40000000, in order, 9 cycles apart.
- DIV 0x3F800000 / 0x00000000 -> rsp_invalid=1, rsp_result=0x00000000.
- cmd_op=3'b101, tag=7 -> rsp 0x7FC00000, invalid=1, tag=7, one cycle after accept; alu_start never asserts.
- rsp_ready=0, push 6 commands -> cmd_ready drops after 4 queued plus 1 popped; no response lost; all 6 return in order once rsp_ready=1.
- Reset asserted 4 cycles after alu_start -> next cycle all outputs at reset values, fifo_count=0; a fresh ADD then completes correctly.
